// File: rtl/shift_seq.sv
// shift_seq: loads a word into an external bidirectional shift register and returns its old contents.
// Build option SHIFT_SEQ_BACK2BACK_EN lets DONE accept the next request directly.
//
// state | meaning
// IDLE  | waiting for a load request
// SHIFT | driving sh/y for WIDTH cycles while capturing q_in
// DONE  | presenting the captured word until out_ready
module shift_seq #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_dir,
    output logic             y,
    output logic             sh,
    output logic             rt,
    input  logic             q_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] data_r, data_nxt;
    logic [WIDTH-1:0] cap_r, cap_nxt, cap_shift;
    logic [WIDTH-1:0] out_data_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             dir_r, dir_nxt;
    logic             y_nxt, sh_nxt, out_valid_nxt;
    logic             accept;

    assign busy = (state != IDLE);
`ifdef SHIFT_SEQ_BACK2BACK_EN
    assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
`else
    assign in_ready = (state == IDLE);
`endif
    assign accept = in_valid && in_ready;
    assign rt     = dir_r;

    // Shifting the capture in from the far end puts sample k at cap[k] (right) or cap[WIDTH-1-k] (left).
    assign cap_shift = dir_r ? {q_in, cap_r[WIDTH-1:1]} : {cap_r[WIDTH-2:0], q_in};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            data_r    <= '0;
            cap_r     <= '0;
            cnt       <= '0;
            dir_r     <= 1'b0;
            y         <= 1'b0;
            sh        <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            state     <= state_nxt;
            data_r    <= data_nxt;
            cap_r     <= cap_nxt;
            cnt       <= cnt_nxt;
            dir_r     <= dir_nxt;
            y         <= y_nxt;
            sh        <= sh_nxt;
            out_valid <= out_valid_nxt;
            out_data  <= out_data_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        data_nxt      = data_r;
        cap_nxt       = cap_r;
        cnt_nxt       = cnt;
        dir_nxt       = dir_r;
        y_nxt         = y;
        sh_nxt        = 1'b0;
        out_valid_nxt = out_valid;
        out_data_nxt  = out_data;

        case (state)
            IDLE: ;
            SHIFT: begin
                cap_nxt = cap_shift;
                cnt_nxt = cnt + CW'(1);
                if (cnt == LAST) begin
                    state_nxt     = DONE;
                    out_valid_nxt = 1'b1;
                    out_data_nxt  = cap_shift;
                end else begin
                    sh_nxt   = 1'b1;
                    y_nxt    = dir_r ? data_r[0] : data_r[WIDTH-1];
                    data_nxt = dir_r ? (data_r >> 1) : (data_r << 1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_nxt = 1'b0;
                    state_nxt     = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // The first bit goes out on the accept edge; data_r keeps the bits still to send.
        if (accept) begin
            state_nxt = SHIFT;
            dir_nxt   = in_dir;
            cnt_nxt   = '0;
            sh_nxt    = 1'b1;
            y_nxt     = in_dir ? in_data[0] : in_data[WIDTH-1];
            data_nxt  = in_dir ? (in_data >> 1) : (in_data << 1);
        end
    end

endmodule

// File: tb/tb_shift_seq.sv
// Bench for shift_seq: models the external shift register and checks transfers against a queue-based reference.
module tb_shift_seq;

    localparam int W = 5;
`ifdef SHIFT_SEQ_BACK2BACK_EN
    localparam int PERIOD = W + 1;
`else
    localparam int PERIOD = W + 2;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, in_dir;
    logic [W-1:0] in_data;
    logic         y, sh, rt, q_in;
    logic         out_valid, out_ready, busy;
    logic [W-1:0] out_data;

    logic [W-1:0] shreg;
    logic [W-1:0] preload_val;
    logic         preload_en;
    logic [W-1:0] exp_reg;

    int n_cmp = 0;
    int n_mis = 0;

    shift_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_dir(in_dir),
        .y(y), .sh(sh), .rt(rt), .q_in(q_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Environment: the 5-bit bidirectional shift register driven by the sequencer.
    always @(posedge clk) begin
        if (preload_en)
            shreg <= preload_val;
        else if (sh)
            shreg <= rt ? {y, shreg[W-1:1]} : {shreg[W-2:0], y};
    end
    assign q_in = rt ? shreg[0] : shreg[W-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (in_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) chk("ready_timeout", 32'(in_ready), 1);
    endtask

    // One complete transfer starting at a negedge in IDLE; hold = cycles of out_ready low in DONE.
    task automatic xfer(input logic [W-1:0] d, input logic dir, input int hold);
        bit           ok;
        logic [W-1:0] s;
        wait_ready(ok);
        if (!ok) return;
        in_valid = 1'b1;
        in_data  = d;
        in_dir   = dir;
        @(negedge clk);
        in_data = W'($urandom);
        in_dir  = ~dir;
        s = d;
        for (int k = 0; k < W; k++) begin
            chk("sh_on", 32'(sh), 1);
            chk("rt", 32'(rt), 32'(dir));
            chk("y", 32'(y), 32'(dir ? s[0] : s[W-1]));
            chk("busy_shift", 32'(busy), 1);
            chk("in_ready_shift", 32'(in_ready), 0);
            chk("ov_shift", 32'(out_valid), 0);
            s = dir ? (s >> 1) : (s << 1);
            in_valid  = 1'($urandom);
            out_ready = 1'($urandom);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("sh_off", 32'(sh), 0);
        chk("out_valid", 32'(out_valid), 1);
        chk("out_data", 32'(out_data), 32'(exp_reg));
        chk("reg_loaded", 32'(shreg), 32'(d));
        chk("rt_hold", 32'(rt), 32'(dir));
        chk("y_hold", 32'(y), 32'(dir ? d[W-1] : d[0]));
        chk("busy_done", 32'(busy), 1);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            @(negedge clk);
            chk("bp_valid", 32'(out_valid), 1);
            chk("bp_data", 32'(out_data), 32'(exp_reg));
            chk("bp_in_ready", 32'(in_ready), 0);
            chk("bp_sh", 32'(sh), 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("rel_valid", 32'(out_valid), 0);
        chk("rel_busy", 32'(busy), 0);
        chk("rel_in_ready", 32'(in_ready), 1);
        exp_reg = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit           ok;
        logic [W-1:0] dd;
        logic [W-1:0] exp_q[$];
        bit           ov_exp;

        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        in_dir      = 1'b0;
        out_ready   = 1'b0;
        preload_en  = 1'b1;
        preload_val = 5'b11001;
        @(negedge clk);
        @(negedge clk);
        preload_en = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_y", 32'(y), 0);
        chk("rst_sh", 32'(sh), 0);
        chk("rst_rt", 32'(rt), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_busy", 32'(busy), 0);
        rst_n   = 1'b1;
        exp_reg = 5'b11001;
        @(negedge clk);

        // Capture right from a preloaded register, then the right/left pair.
        xfer(5'b00000, 1'b1, 0);
        xfer(5'b10110, 1'b1, 0);
        xfer(5'b01011, 1'b0, 4);

        // Abort after two shifts.
        dd = 5'b11100;
        wait_ready(ok);
        in_valid = 1'b1;
        in_data  = dd;
        in_dir   = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_sh", 32'(sh), 0);
        chk("abort_in_ready", 32'(in_ready), 1);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_ov", 32'(out_valid), 0);
        chk("abort_rt", 32'(rt), 0);
        exp_reg = {dd[1], dd[0], exp_reg[W-1:2]};
        chk("abort_reg", 32'(shreg), 32'(exp_reg));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        xfer(5'b00111, 1'b0, 1);

        for (int t = 0; t < 10; t++)
            xfer(W'($urandom), 1'($urandom), int'($urandom_range(0, 3)));

        // Streaming: in_valid and out_ready held high, period depends on the build option.
        wait_ready(ok);
        exp_q.push_back(exp_reg);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int c = 0; c <= 4 * PERIOD; c++) begin
            if (c > 0) begin
                chk("str_sh", 32'(sh), 32'(((c - 1) % PERIOD) < W));
                ov_exp = (c >= W + 1) && (((c - W - 1) % PERIOD) == 0);
                chk("str_ov", 32'(out_valid), 32'(ov_exp));
                if (ov_exp && exp_q.size() > 0)
                    chk("str_data", 32'(out_data), 32'(exp_q.pop_front()));
            end
            if (c < 4 * PERIOD) begin
                in_data = W'($urandom);
                in_dir  = 1'($urandom);
                if ((c % PERIOD) == 0) exp_q.push_back(in_data);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        out_ready = 1'b0;
        chk("str_left", 32'(exp_q.size()), 1);
        if (exp_q.size() > 0) exp_reg = exp_q.pop_front();
        chk("str_reg", 32'(shreg), 32'(exp_reg));
        chk("str_idle", 32'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
